gpi_periph: RTL and testbench

// Memory-mapped general-purpose input peripheral; the read-side counterpart of the GPO output port.

---
 rtl/gpi_periph.sv | 111 +++++++++++
 tb/tb_gpi_periph.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_periph.sv
// General-purpose input peripheral: synchronised, debounced pins with sticky edge flags,
// a masked level interrupt and a registered memory-mapped read port.
module gpi_periph #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [9:0]  BASE_ADDR       = 10'h54
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       address,
    input  logic [31:0]      data_in,
    input  logic             write,
    output logic [31:0]      data_out,
    input  logic [WIDTH-1:0] pins,
    output logic             irq
);

    localparam int unsigned   CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]    ADDR_LEVEL = BASE_ADDR;
    localparam logic [9:0]    ADDR_RISE  = BASE_ADDR + 10'd4;
    localparam logic [9:0]    ADDR_FALL  = BASE_ADDR + 10'd8;
    localparam logic [9:0]    ADDR_MASK  = BASE_ADDR + 10'd12;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_mask;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_level_d;
    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] w_fall_set;
    logic [WIDTH-1:0] w_rise_clr;
    logic [WIDTH-1:0] w_fall_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata;
    logic [CW-1:0]    w_cnt_d [WIDTH];
    logic             w_unused_data;

    assign w_wdata       = data_in[WIDTH-1:0];
    assign w_unused_data = ^(data_in >> WIDTH);

    // A new level must differ from LEVEL on DEBOUNCE_CYCLES consecutive edges to be accepted.
    always_comb begin
        w_level_d  = r_level;
        w_rise_set = '0;
        w_fall_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_d[i] = '0;
            if (r_s2[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_level_d[i]  = r_s2[i];
                    w_rise_set[i] = r_s2[i];
                    w_fall_set[i] = ~r_s2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rise_clr = (write && (address == ADDR_RISE)) ? w_wdata : '0;
        w_fall_clr = (write && (address == ADDR_FALL)) ? w_wdata : '0;
    end

    always_comb begin
        case (address)
            ADDR_LEVEL: w_rdata = r_level;
            ADDR_RISE:  w_rdata = r_rise;
            ADDR_FALL:  w_rdata = r_fall;
            ADDR_MASK:  w_rdata = r_mask;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_level  <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_mask   <= '0;
            data_out <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1    <= pins;
            r_s2    <= r_s1;
            r_level <= w_level_d;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            // Hardware set wins over a same-edge write-one-to-clear.
            r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
            r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
            if (write && (address == ADDR_MASK)) begin
                r_mask <= w_wdata;
            end
            data_out <= 32'(w_rdata);
            irq      <= |((r_rise | r_fall) & r_mask);
        end
    end

endmodule

// File: tb/tb_gpi_periph.sv
// Bench for gpi_periph: directed scenarios followed by randomized traffic, every cycle
// compared against a history-based reference model of the register map.
module tb_gpi_periph;

    localparam int         W      = 8;
    localparam int         D      = 4;
    localparam logic [9:0] A_LVL  = 10'h54;
    localparam logic [9:0] A_RISE = 10'h58;
    localparam logic [9:0] A_FALL = 10'h5C;
    localparam logic [9:0] A_MASK = 10'h60;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic        write;
    logic [31:0] data_out;
    logic [7:0]  pins;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  m_level, m_rise, m_fall, m_mask;
    logic [31:0] m_dout;
    logic        m_irq;
    logic [7:0]  pin_hist [$];
    logic [7:0]  s2_hist [$];
    int          last_acc [8];
    int          n_edge;

    always #5 clk = ~clk;

    gpi_periph #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .BASE_ADDR      (A_LVL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data_in (data_in),
        .write   (write),
        .data_out(data_out),
        .pins    (pins),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [9:0] a);
        case (a)
            A_LVL:   return 32'(m_level);
            A_RISE:  return 32'(m_rise);
            A_FALL:  return 32'(m_fall);
            A_MASK:  return 32'(m_mask);
            default: return 32'h0;
        endcase
    endfunction

    // Pins reach the logic two edges late; a bit is accepted once its delayed value has
    // disagreed with the accepted level on every one of the last D edges since its last change.
    task automatic model_edge();
        logic [7:0] s2, set_r, set_f;
        bit         ok;
        if (reset) begin
            m_level = 0; m_rise = 0; m_fall = 0; m_mask = 0; m_dout = 0; m_irq = 0;
            pin_hist.delete();
            s2_hist.delete();
            for (int i = 0; i < 8; i++) last_acc[i] = 0;
            n_edge = 0;
            return;
        end
        m_dout = m_read(address);
        m_irq  = |((m_rise | m_fall) & m_mask);
        n_edge++;
        pin_hist.push_back(pins);
        s2 = (n_edge >= 3) ? pin_hist[n_edge-3] : 8'h00;
        s2_hist.push_back(s2);
        set_r = 0;
        set_f = 0;
        for (int i = 0; i < 8; i++) begin
            if (n_edge - D >= last_acc[i]) begin
                ok = 1;
                for (int k = n_edge - D + 1; k <= n_edge; k++)
                    if (s2_hist[k-1][i] == m_level[i]) ok = 0;
                if (ok) begin
                    last_acc[i] = n_edge;
                    m_level[i]  = ~m_level[i];
                    if (m_level[i]) set_r[i] = 1'b1;
                    else            set_f[i] = 1'b1;
                end
            end
        end
        if (write) begin
            if (address == A_RISE) m_rise = m_rise & ~data_in[7:0];
            if (address == A_FALL) m_fall = m_fall & ~data_in[7:0];
            if (address == A_MASK) m_mask = data_in[7:0];
        end
        m_rise = m_rise | set_r;
        m_fall = m_fall | set_f;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cyc_dout", data_out, m_dout);
        check("cyc_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        write = 1'b0;
        repeat (n) step();
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        write   = 1'b1;
        step();
        write   = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [9:0] a, input logic [31:0] exp);
        address = a;
        write   = 1'b0;
        step();
        check(tag, data_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with pins high, then the rise latency
        reset = 1'b1; pins = 8'hFF; address = A_LVL; write = 1'b0; data_in = 32'h0;
        step();
        step();
        check("rst_dout", data_out, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        rd_expect("rst_rise", A_RISE, 32'h0);
        rd_expect("rst_fall", A_FALL, 32'h0);
        rd_expect("rst_mask", A_MASK, 32'h0);
        rd_expect("lvl_e4", A_LVL, 32'h0);
        rd_expect("lvl_e5", A_LVL, 32'h0);
        rd_expect("rise_e6", A_RISE, 32'h0);
        rd_expect("lvl_e7", A_LVL, 32'hFF);
        rd_expect("rise_e8", A_RISE, 32'hFF);

        // 2: glitch one cycle shorter than the debounce window
        reset = 1'b1; pins = 8'h00;
        step();
        reset = 1'b0;
        pins = 8'h01;
        idle(3);
        pins = 8'h00;
        idle(10);
        rd_expect("glitch_lvl", A_LVL, 32'h0);
        rd_expect("glitch_rise", A_RISE, 32'h0);
        rd_expect("glitch_fall", A_FALL, 32'h0);

        // 3: falling flag and W1C
        pins = 8'h08;
        idle(8);
        pins = 8'h00;
        idle(8);
        rd_expect("fall_set", A_FALL, 32'h08);
        wr(A_FALL, 32'h08);
        rd_expect("fall_clr", A_FALL, 32'h0);

        // 4: W1C on the same edge the rising event is accepted
        wr(A_RISE, 32'hFF);
        pins = 8'h04;
        idle(5);
        wr(A_RISE, 32'h04);
        rd_expect("collide", A_RISE, 32'h04);

        // 5: interrupt
        wr(A_MASK, 32'h01);
        pins = 8'h05;
        idle(6);
        check("irq_pre", 32'(irq), 32'h0);
        idle(1);
        check("irq_set", 32'(irq), 32'h1);
        wr(A_MASK, 32'h0);
        check("irq_hold", 32'(irq), 32'h1);
        idle(1);
        check("irq_masked", 32'(irq), 32'h0);
        wr(A_RISE, 32'hFF);
        wr(A_MASK, 32'h01);
        idle(3);
        check("irq_stays", 32'(irq), 32'h0);

        // 6: decode
        wr(10'h50, 32'hFFFF_FFFF);
        wr(A_LVL, 32'hFFFF_FFFF);
        wr(A_LVL + 10'd2, 32'hFFFF_FFFF);
        rd_expect("dec_lvl", A_LVL, 32'h05);
        rd_expect("dec_rise", A_RISE, 32'h0);
        rd_expect("dec_fall", A_FALL, 32'h0);
        rd_expect("dec_mask", A_MASK, 32'h01);
        rd_expect("dec_misal", A_LVL + 10'd2, 32'h0);
        rd_expect("dec_3ff", 10'h3FF, 32'h0);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int hold;
            hold = $urandom_range(1, 2 * D + 2);
            if ($urandom_range(0, 1) == 0) pins = 8'($urandom);
            else pins = pins ^ (8'h01 << $urandom_range(0, 7));
            for (int c = 0; c < hold; c++) begin
                reset   = ($urandom_range(0, 199) == 0);
                write   = ($urandom_range(0, 3) == 0);
                data_in = $urandom;
                case ($urandom_range(0, 7))
                    0: address = A_LVL;
                    1: address = A_RISE;
                    2: address = A_FALL;
                    3: address = A_MASK;
                    4: address = A_LVL + 10'd2;
                    5: address = 10'h50;
                    6: address = 10'h3FF;
                    default: address = 10'($urandom);
                endcase
                step();
            end
        end
        reset = 1'b0;
        write = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
